// File: rtl/regread_port_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// Optional macro REGREAD_ZERO_BYPASS_EN serves reads of address 0 without the port.
module regread_port_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] raddr,
    input  logic               hold,
    output logic [NREQ-1:0]    gnt,
    output logic [AW-1:0]      port_sel,
    input  logic [DW-1:0]      port_data,
    output logic [NREQ*DW-1:0] rdata,
    output logic [NREQ-1:0]    rvalid
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   rr_ptr;
    logic [NREQ-1:0] byp;
    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] port_gnt;
    logic            found;

`ifdef REGREAD_ZERO_BYPASS_EN
    always_comb begin
        byp = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            byp[i] = req[i] && (raddr[i*AW +: AW] == '0);
    end
`else
    assign byp = '0;
`endif

    assign arb_req = req & ~byp;

    // Scan from rr_ptr upward with wrap; the first pending index wins the port.
    always_comb begin
        port_gnt = '0;
        found    = 1'b0;
        if (!hold) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (!found && arb_req[i] && (i == (32'(rr_ptr) + k) % NREQ)) begin
                        found       = 1'b1;
                        port_gnt[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Only the granted slice reaches the mux, so X on idle slices stays out.
    always_comb begin
        port_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            if (port_gnt[i])
                port_sel = raddr[i*AW +: AW];
    end

    assign gnt = port_gnt | byp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= port_gnt | byp;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (byp[i]) begin
                    rdata[i*DW +: DW] <= '0;
                end else if (port_gnt[i]) begin
                    rdata[i*DW +: DW] <= port_data;
                    rr_ptr            <= (i == NREQ - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_regread_port_arbiter.sv
// Self-checking bench for regread_port_arbiter: per-cycle reference model plus
// directed vectors with literal expectations.
module tb_regread_port_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*AW-1:0] raddr = '0;
    logic               hold = 1'b0;
    logic [NREQ-1:0]    gnt;
    logic [AW-1:0]      port_sel;
    logic [DW-1:0]      port_data = '0;
    logic [NREQ*DW-1:0] rdata;
    logic [NREQ-1:0]    rvalid;

    regread_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .req(req), .raddr(raddr), .hold(hold),
        .gnt(gnt), .port_sel(port_sel), .port_data(port_data),
        .rdata(rdata), .rvalid(rvalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model state
    int unsigned     mptr = 0;
    logic [DW-1:0]   mdata [NREQ];
    logic [NREQ-1:0] mvalid = '0;

    function automatic logic [NREQ-1:0] bypass_of(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a);
        logic [NREQ-1:0] b;
        b = '0;
`ifdef REGREAD_ZERO_BYPASS_EN
        for (int i = 0; i < NREQ; i++)
            if (r[i] === 1'b1 && a[i*AW +: AW] === '0) b[i] = 1'b1;
`endif
        return b;
    endfunction

    function automatic logic [NREQ-1:0] exp_gnt(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a,
                                               input logic h, input int unsigned p);
        logic [NREQ-1:0] b, g;
        bit done;
        b = bypass_of(r, a);
        g = b;
        done = 0;
        if (!h) begin
            for (int unsigned off = 0; off < NREQ; off++) begin
                int unsigned idx;
                idx = (p + off) % NREQ;
                if (!done && r[idx] && !b[idx]) begin
                    g[idx] = 1'b1;
                    done = 1;
                end
            end
        end
        return g;
    endfunction

    function automatic logic [AW-1:0] exp_sel(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a,
                                             input logic h, input int unsigned p);
        logic [NREQ-1:0] pg;
        pg = exp_gnt(r, a, h, p) & ~bypass_of(r, a);
        for (int i = 0; i < NREQ; i++)
            if (pg[i]) return a[i*AW +: AW];
        return '0;
    endfunction

    function automatic logic [NREQ*DW-1:0] packed_mdata();
        logic [NREQ*DW-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i*DW +: DW] = mdata[i];
        return v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mptr   = 0;
            mvalid = '0;
            for (int i = 0; i < NREQ; i++) mdata[i] = '0;
        end else begin
            logic [NREQ-1:0] g, b;
            g = exp_gnt(req, raddr, hold, mptr);
            b = bypass_of(req, raddr);
            mvalid = g;
            for (int i = 0; i < NREQ; i++) begin
                if (b[i]) mdata[i] = '0;
                else if (g[i]) begin
                    mdata[i] = port_data;
                    mptr = (i + 1) % NREQ;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("model_gnt", gnt, exp_gnt(req, raddr, hold, mptr));
        chk("model_port_sel", port_sel, exp_sel(req, raddr, hold, mptr));
        chk("model_rvalid", rvalid, mvalid);
        chk("model_rdata", rdata, packed_mdata());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [NREQ*AW-1:0] ADDRS = {5'd4, 5'd3, 5'd2, 5'd1};

    initial begin
        for (int i = 0; i < NREQ; i++) mdata[i] = '0;
        raddr = ADDRS;
        #1 reset = 1'b1;
        req = 4'b1111;
        repeat (2) @(negedge clk);
        chk("reset_rvalid", rvalid, 4'b0000);
        chk("reset_rdata", rdata, 128'd0);
        chk("reset_gnt", gnt, 4'b0001);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("first_gnt", gnt, 4'b0001);

        // Single read, idle slices driven X
        step();
        req = 4'b0100;
        raddr = 'x;
        raddr[10 +: 5] = 5'd7;
        port_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("single_gnt", gnt, 4'b0100);
        chk("single_sel", port_sel, 5'd7);
        step();
        req = 4'b0000;
        raddr = ADDRS;
        port_data = '0;
        @(negedge clk);
        chk("single_rvalid", rvalid, 4'b0100);
        chk("single_rdata", rdata[64 +: 32], 32'hDEADBEEF);

        // Wrap from pointer 3, then reset during the grant to 0
        step();
        req = 4'b1001;
        port_data = 32'h0000_3333;
        @(negedge clk);
        chk("wrap_gnt3", gnt, 4'b1000);
        step();
        req = 4'b0001;
        port_data = 32'h0000_1111;
        @(negedge clk);
        chk("wrap_gnt0", gnt, 4'b0001);
        chk("wrap_rvalid3", rvalid, 4'b1000);
        #1 reset = 1'b1;
        #1 chk("midreset_rvalid", rvalid, 4'b0000);
        chk("midreset_rdata", rdata, 128'd0);
        step();
        reset = 1'b0;
        req = 4'b1111;

        // Round robin from pointer 0
        for (int c = 0; c < 8; c++) begin
            port_data = 32'hA000_0000 + 32'(c);
            @(negedge clk);
            chk("rr_gnt", gnt, 4'b0001 << (c % 4));
            if (c > 0) chk("rr_rvalid", rvalid, 4'b0001 << ((c - 1) % 4));
            step();
        end

        // Hold keeps the request pending
        req = 4'b0010;
        hold = 1'b1;
        port_data = 32'h0BAD_F00D;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk("hold_gnt", gnt, 4'b0000);
            if (h == 0) chk("hold_rvalid_last_rr", rvalid, 4'b1000);
            else chk("hold_rvalid", rvalid, 4'b0000);
            step();
        end
        hold = 1'b0;
        @(negedge clk);
        chk("unhold_gnt", gnt, 4'b0010);
        step();
        req = 4'b0000;
        @(negedge clk);
        chk("unhold_rvalid", rvalid, 4'b0010);
        chk("unhold_rdata", rdata[32 +: 32], 32'h0BAD_F00D);

        // Address 0 handling
        step();
        req = 4'b0011;
        raddr = {5'd4, 5'd3, 5'd9, 5'd0};
        port_data = 32'h0000_1234;
        @(negedge clk);
`ifdef REGREAD_ZERO_BYPASS_EN
        chk("zero_gnt", gnt, 4'b0011);
        chk("zero_sel", port_sel, 5'd9);
        step();
        req = 4'b0000;
        @(negedge clk);
        chk("zero_rvalid", rvalid, 4'b0011);
        chk("zero_rdata0", rdata[0 +: 32], 32'd0);
        chk("zero_rdata1", rdata[32 +: 32], 32'h0000_1234);
        step();
        req = 4'b0001;
        hold = 1'b1;
        @(negedge clk);
        chk("zero_hold_gnt", gnt, 4'b0001);
        step();
        req = 4'b0000;
        hold = 1'b0;
        @(negedge clk);
        chk("zero_hold_rvalid", rvalid, 4'b0001);
`else
        chk("zero_gnt", gnt, 4'b0001);
        chk("zero_sel", port_sel, 5'd0);
        step();
        req = 4'b0010;
        @(negedge clk);
        chk("zero_rvalid", rvalid, 4'b0001);
        chk("zero_rdata0", rdata[0 +: 32], 32'h0000_1234);
        chk("zero_next_gnt", gnt, 4'b0010);
        step();
        req = 4'b0000;
        @(negedge clk);
        chk("zero_next_rvalid", rvalid, 4'b0010);
`endif
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
